// File: rtl/timer_sequencer_pkg.sv
// timer_sequencer_pkg: shared state encoding and default sizing for the timer sequencer
package timer_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        ABORT = 2'd3
    } state_e;

    localparam int CW_DEF    = 16;
    localparam int TW_DEF    = 4;
    localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/timer_sequencer_fifo.sv
// timer_sequencer_fifo: synchronous request FIFO with push/pop/flush and occupancy
module timer_sequencer_fifo #(
    parameter  int W     = 20,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;
    logic         do_push;
    logic         do_pop;

    // Flush wins over everything, so a push racing an abort is dropped.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    // The extra pointer bit separates full from empty; the difference wraps naturally.
    assign level_o = wptr_q - rptr_q;
    assign full_o  = level_o == (AW+1)'(DEPTH);
    assign empty_o = wptr_q == rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Pointer update: flush empties, otherwise advance on accepted push/pop.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i) !(push_i && full_o));
    a_level_bound:  assert property (@(posedge clk_i) disable iff (reset_i) level_o <= (AW+1)'(DEPTH));

endmodule

// File: rtl/timer_sequencer.sv
// timer_sequencer: queues tagged delay requests and issues them one at a time to a one-shot timer
module timer_sequencer
    import timer_sequencer_pkg::*;
#(
    parameter  int CW    = CW_DEF,
    parameter  int TW    = TW_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [CW-1:0] req_cycles_i,
    input  logic [TW-1:0] req_tag_i,
    input  logic          abort_i,
    output logic          timer_load_o,
    output logic [CW-1:0] timer_cycles_o,
    input  logic          timer_busy_i,
    output logic          done_o,
    output logic [TW-1:0] done_tag_o,
    output logic [LW-1:0] level_o
);

    state_e             state_q;
    state_e             state_d;
    logic [CW-1:0]      cur_cycles_q;
    logic [TW-1:0]      cur_tag_q;
    logic [CW+TW-1:0]   head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign req_ready_o = !full;
    assign push        = req_valid_i && req_ready_o;
    // Head is taken when idle, or as the running interval expires so the next load is adjacent.
    assign pop = !abort_i && !empty && (state_q == IDLE || (state_q == RUN && !timer_busy_i));

    timer_sequencer_fifo #(
        .W     (CW + TW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (abort_i),
        .wdata_i ({req_cycles_i, req_tag_i}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state: abort overrides; an active interval is cancelled through ABORT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = empty ? IDLE : LOAD;
            LOAD:    state_d = RUN;
            RUN:     state_d = timer_busy_i ? RUN : (empty ? IDLE : LOAD);
            default: state_d = IDLE;
        endcase
        if (abort_i) state_d = (state_q == LOAD || state_q == RUN) ? ABORT : IDLE;
    end

    // Capture the popped request for the interval about to be loaded.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cur_cycles_q <= '0;
            cur_tag_q    <= '0;
        end else if (pop) begin
            {cur_cycles_q, cur_tag_q} <= head;
        end
    end

    // Outputs: an abort arriving in LOAD suppresses that load so the strobe never spans two cycles.
    always_comb begin
        timer_load_o   = (state_q == LOAD && !abort_i) || state_q == ABORT;
        timer_cycles_o = (state_q == LOAD && !abort_i) ? cur_cycles_q : '0;
        done_o         = state_q == RUN && !timer_busy_i && !abort_i;
        done_tag_o     = (state_q == RUN && !timer_busy_i && !abort_i) ? cur_tag_q : '0;
    end

    a_done_pulse: assert property (@(posedge clk_i) disable iff (reset_i) done_o |=> !done_o);
    a_load_pulse: assert property (@(posedge clk_i) disable iff (reset_i) timer_load_o |=> !timer_load_o);
    a_load_idle:  assert property (@(posedge clk_i) disable iff (reset_i)
                                   (timer_load_o && state_q != ABORT) |-> !timer_busy_i);

endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: directed checks of the timer sequencer against a behavioural one-shot timer
module tb_timer_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_cycles = '0;
    logic [3:0]  req_tag = '0;
    logic        abort = 1'b0;
    logic        timer_load;
    logic [15:0] timer_cycles;
    logic        timer_busy;
    logic        done;
    logic [3:0]  done_tag;
    logic [2:0]  level;
    logic [15:0] tcnt;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    timer_sequencer dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_cycles_i   (req_cycles),
        .req_tag_i      (req_tag),
        .abort_i        (abort),
        .timer_load_o   (timer_load),
        .timer_cycles_o (timer_cycles),
        .timer_busy_i   (timer_busy),
        .done_o         (done),
        .done_tag_o     (done_tag),
        .level_o        (level)
    );

    // One-shot timer: load sets the counter, busy while non-zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           tcnt <= '0;
        else if (timer_load) tcnt <= timer_cycles;
        else if (tcnt != 0)  tcnt <= tcnt - 16'd1;
    end
    assign timer_busy = tcnt != 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] c, input logic [3:0] t);
        req_valid  = v;
        req_cycles = c;
        req_tag    = t;
    endtask

    // Entered in the LOAD cycle; ends in the cycle carrying the done pulse.
    task automatic run_to_done(input int n, input logic [3:0] t);
        chk("load_strobe", timer_load, 1);
        chk("load_cycles", timer_cycles, n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("run_busy_nodone", {timer_busy, done}, 2'b10);
        end
        step();
        chk("done_pulse", done, 1);
        chk("done_tag", done_tag, t);
    endtask

    // Push one request into an idle, empty sequencer and follow it to completion.
    task automatic single(input int n, input logic [3:0] t);
        drive(1, 16'(n), t);
        step();
        drive(0, 0, 0);
        chk("single_queued", level, 1);
        chk("single_noload_yet", timer_load, 0);
        step();
        run_to_done(n, t);
        step();
        chk("single_done_once", done, 0);
        chk("single_idle_noload", timer_load, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_level", level, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_load", timer_load, 0);
        chk("rst_cycles", timer_cycles, 0);
        chk("rst_done", done, 0);
        chk("rst_done_tag", done_tag, 0);
        reset = 1'b0;
        step();

        // single interval
        single(3, 4'd5);

        // zero-length interval: done directly after load, timer never busy
        drive(1, 0, 4'd1);
        step();
        drive(0, 0, 0);
        step();
        run_to_done(0, 4'd1);
        chk("zero_no_busy", timer_busy, 0);
        step();
        chk("zero_done_once", done, 0);

        // back-to-back queue: 2,4,1 with tags 1,2,3
        drive(1, 16'd2, 4'd1);
        step();
        drive(1, 16'd4, 4'd2);
        step();
        chk("q_load_a", timer_load, 1);
        chk("q_cycles_a", timer_cycles, 2);
        drive(1, 16'd1, 4'd3);
        step();
        drive(0, 0, 0);
        chk("q_level", level, 2);
        chk("q_busy_a1", timer_busy, 1);
        step();
        chk("q_busy_a2", timer_busy, 1);
        step();
        chk("q_done_a", done, 1);
        chk("q_tag_a", done_tag, 1);
        step();
        run_to_done(4, 4'd2);
        step();
        run_to_done(1, 4'd3);
        step();
        chk("q_idle_noload", timer_load, 0);
        chk("q_empty", level, 0);

        // full FIFO while a long interval runs; the fifth beat must be held
        drive(1, 16'd20, 4'd7);
        step();
        drive(0, 0, 0);
        step();
        chk("f_load_long", timer_load, 1);
        step();
        for (int t = 8; t <= 11; t++) begin
            drive(1, 16'd1, 4'(t));
            step();
        end
        drive(1, 16'd1, 4'd12);
        chk("f_level_full", level, 4);
        chk("f_not_ready", req_ready, 0);
        step();
        chk("f_level_held", level, 4);
        chk("f_still_not_ready", req_ready, 0);
        for (int i = 0; i < 40 && !done; i++) step();
        chk("f_done_long", done, 1);
        chk("f_tag_long", done_tag, 7);
        step();
        chk("f_load_adjacent", timer_load, 1);
        chk("f_level_after_pop", level, 3);
        chk("f_ready_again", req_ready, 1);
        step();
        drive(0, 0, 0);
        chk("f_extra_accepted", level, 4);
        chk("f_busy8", timer_busy, 1);
        step();
        chk("f_done8", done, 1);
        chk("f_tag8", done_tag, 8);
        for (int t = 9; t <= 12; t++) begin
            step();
            run_to_done(1, 4'(t));
        end
        step();
        chk("f_drained", level, 0);

        // abort mid-run with two more queued and a push in the abort cycle
        drive(1, 16'd10, 4'd1);
        step();
        drive(1, 16'd5, 4'd2);
        step();
        drive(1, 16'd5, 4'd3);
        step();
        drive(0, 0, 0);
        chk("a_level_queued", level, 2);
        step();
        step();
        abort = 1'b1;
        drive(1, 16'd5, 4'd9);
        #1;
        chk("a_no_done_abort", done, 0);
        step();
        abort = 1'b0;
        drive(0, 0, 0);
        chk("a_abort_load", timer_load, 1);
        chk("a_abort_cycles", timer_cycles, 0);
        chk("a_flushed", level, 0);
        step();
        chk("a_idle_noload", timer_load, 0);
        chk("a_timer_stopped", timer_busy, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("a_quiet", {done, timer_load}, 2'b00);
        end

        // abort landing exactly on the expiry cycle beats done
        drive(1, 16'd2, 4'd3);
        step();
        drive(0, 0, 0);
        step();
        step();
        step();
        step();
        abort = 1'b1;
        #1;
        chk("p_done_suppressed", done, 0);
        chk("p_tag_suppressed", done_tag, 0);
        step();
        abort = 1'b0;
        chk("p_abort_load", timer_load, 1);
        chk("p_abort_cycles", timer_cycles, 0);
        step();
        chk("p_idle", {done, timer_load}, 2'b00);

        // asynchronous reset during LOAD with one request still queued
        drive(1, 16'd8, 4'd4);
        step();
        drive(1, 16'd3, 4'd6);
        step();
        drive(0, 0, 0);
        chk("r_load_before", timer_load, 1);
        chk("r_level_before", level, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("r_load_drop", timer_load, 0);
        chk("r_cycles_drop", timer_cycles, 0);
        chk("r_level_drop", level, 0);
        chk("r_ready", req_ready, 1);
        chk("r_done", done, 0);
        step();
        step();
        reset = 1'b0;
        step();
        single(3, 4'd5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
